pwm_softstart_ctrl: RTL and testbench

Sequencing controller for the half-bridge PWM generator. It owns that generator's `duty`, `half_period`, `deadtime` and `protection` inputs. It soft-starts the duty from zero, slews it toward a target with a bounded step, and applies changes only at carrier-period boundaries. It latches faults and ramps down cleanly on disable. It sits between the host/regulation logic and the PWM generator, one instance per bridge.

---
 rtl/pwm_softstart_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pwm_softstart_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_softstart_ctrl.sv
// Soft-start sequencer for one half-bridge PWM generator: slews duty toward a clamped target
// one bounded step per carrier period, latches faults and ramps down cleanly on disable.
module pwm_softstart_ctrl #(
  parameter logic [20:0] STEP   = 21'd1,
  parameter logic [20:0] HP_RST = 21'd1000,
  parameter logic [20:0] DT_RST = 21'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_fault,
  input  logic        i_fault_clr,
  input  logic [20:0] i_tgt_duty,
  input  logic [20:0] i_tgt_half_period,
  input  logic [20:0] i_tgt_deadtime,
  output logic [20:0] o_duty,
  output logic [20:0] o_half_period,
  output logic [20:0] o_deadtime,
  output logic        o_protection,
  output logic [1:0]  o_state,
  output logic        o_period_tick,
  output logic        o_cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_RUN,
    S_STOP,
    S_FAULT
  } state_t;

  state_t      r_state, w_stateNext;
  logic [21:0] r_pcnt, w_pcntNext;
  logic [20:0] r_duty, w_dutyNext;
  logic [20:0] r_hp, w_hpNext;
  logic [20:0] r_dt, w_dtNext;
  logic        r_prot, w_protNext;
  logic        r_tick, w_tickNext;
  logic        r_cfgErr, w_cfgErrNext;
  logic [1:0]  r_stateCode, w_stateCode;

  logic [20:0] w_dmax, w_target, w_diffUp, w_diffDown, w_slew, w_down;
  logic        w_running, w_wrap, w_cfgOk;

  // Ceiling keeps the on-time clear of the dead band; the target is the live request clamped to it.
  assign w_dmax     = (r_hp > r_dt + 21'd1) ? (r_hp - r_dt - 21'd1) : 21'd0;
  assign w_target   = (i_tgt_duty < w_dmax) ? i_tgt_duty : w_dmax;
  assign w_diffUp   = (w_target > r_duty) ? (w_target - r_duty) : 21'd0;
  assign w_diffDown = (r_duty > w_target) ? (r_duty - w_target) : 21'd0;
  assign w_down     = (r_duty > STEP) ? (r_duty - STEP) : 21'd0;
  assign w_running  = (r_state == S_RAMP) || (r_state == S_RUN) || (r_state == S_STOP);
  assign w_wrap     = w_running && (r_pcnt == ({1'b0, r_hp} << 1) - 22'd1);
  assign w_cfgOk    = (i_tgt_half_period >= 21'd4) &&
                      (i_tgt_deadtime < i_tgt_half_period - 21'd1);

  always_comb begin
    w_slew = r_duty;
    if (w_diffUp != 21'd0) begin
      w_slew = r_duty + ((w_diffUp > STEP) ? STEP : w_diffUp);
    end else if (w_diffDown != 21'd0) begin
      w_slew = r_duty - ((w_diffDown > STEP) ? STEP : w_diffDown);
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_pcntNext   = r_pcnt;
    w_dutyNext   = r_duty;
    w_hpNext     = r_hp;
    w_dtNext     = r_dt;
    w_protNext   = r_prot;
    w_tickNext   = w_wrap;
    w_cfgErrNext = r_cfgErr & ~i_fault_clr;

    if (w_running) begin
      w_pcntNext = w_wrap ? 22'd0 : r_pcnt + 22'd1;
    end

    // Fault outranks enable changes and any tick landing on the same edge.
    if (i_fault) begin
      w_stateNext = S_FAULT;
      w_pcntNext  = 22'd0;
      w_dutyNext  = 21'd0;
      w_protNext  = 1'b1;
      w_tickNext  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_dutyNext = 21'd0;
          w_protNext = 1'b1;
          w_pcntNext = 22'd0;
          if (i_enable) begin
            if (w_cfgOk) begin
              w_hpNext    = i_tgt_half_period;
              w_dtNext    = i_tgt_deadtime;
              w_protNext  = 1'b0;
              w_stateNext = S_RAMP;
            end else begin
              w_cfgErrNext = 1'b1;
            end
          end
        end
        S_RAMP, S_RUN: begin
          if (!i_enable) begin
            w_stateNext = S_STOP;
            if (w_wrap) w_dutyNext = w_down;
          end else if (w_wrap) begin
            w_dutyNext = w_slew;
            if (r_state == S_RAMP && w_slew == w_target) w_stateNext = S_RUN;
          end
        end
        S_STOP: begin
          if (i_enable) begin
            w_stateNext = S_RAMP;
          end else if (w_wrap) begin
            if (r_duty == 21'd0) begin
              w_stateNext = S_IDLE;
              w_protNext  = 1'b1;
              w_pcntNext  = 22'd0;
            end else begin
              w_dutyNext = w_down;
            end
          end
        end
        S_FAULT: begin
          w_dutyNext = 21'd0;
          w_protNext = 1'b1;
          w_pcntNext = 22'd0;
          if (i_fault_clr) w_stateNext = S_IDLE;
        end
        default: begin
          w_stateNext = S_IDLE;
          w_protNext  = 1'b1;
          w_dutyNext  = 21'd0;
          w_pcntNext  = 22'd0;
        end
      endcase
    end

    case (w_stateNext)
      S_IDLE:  w_stateCode = 2'd0;
      S_RUN:   w_stateCode = 2'd2;
      S_FAULT: w_stateCode = 2'd3;
      default: w_stateCode = 2'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pcnt      <= 22'd0;
      r_duty      <= 21'd0;
      r_hp        <= HP_RST;
      r_dt        <= DT_RST;
      r_prot      <= 1'b1;
      r_tick      <= 1'b0;
      r_cfgErr    <= 1'b0;
      r_stateCode <= 2'd0;
    end else begin
      r_state     <= w_stateNext;
      r_pcnt      <= w_pcntNext;
      r_duty      <= w_dutyNext;
      r_hp        <= w_hpNext;
      r_dt        <= w_dtNext;
      r_prot      <= w_protNext;
      r_tick      <= w_tickNext;
      r_cfgErr    <= w_cfgErrNext;
      r_stateCode <= w_stateCode;
    end
  end

  assign o_duty        = r_duty;
  assign o_half_period = r_hp;
  assign o_deadtime    = r_dt;
  assign o_protection  = r_prot;
  assign o_state       = r_stateCode;
  assign o_period_tick = r_tick;
  assign o_cfg_err     = r_cfgErr;

endmodule

// File: tb/tb_pwm_softstart_ctrl.sv
// Self-checking bench for pwm_softstart_ctrl: config-check vector table plus a per-tick
// duty scoreboard covering soft-start, clamp, ramp-down, fault and async reset.
module tb_pwm_softstart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, fault, faultClr;
  logic [20:0] tgtDuty, tgtHp, tgtDt;
  logic [20:0] duty, halfPeriod, deadtime;
  logic        protection, periodTick, cfgErr;
  logic [1:0]  state;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [20:0] hp;
    logic [20:0] dt;
    logic        expErr;
    logic [1:0]  expState;
  } cfgVec_t;

  typedef struct {
    logic [20:0] duty;
    logic [1:0]  state;
    logic        prot;
  } tickExp_t;

  cfgVec_t  cfgTable[7];
  tickExp_t sbQ[$];

  pwm_softstart_ctrl #(
    .STEP  (21'd10),
    .HP_RST(21'd1000),
    .DT_RST(21'd10)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_enable         (enable),
    .i_fault          (fault),
    .i_fault_clr      (faultClr),
    .i_tgt_duty       (tgtDuty),
    .i_tgt_half_period(tgtHp),
    .i_tgt_deadtime   (tgtDt),
    .o_duty           (duty),
    .o_half_period    (halfPeriod),
    .o_deadtime       (deadtime),
    .o_protection     (protection),
    .o_state          (state),
    .o_period_tick    (periodTick),
    .o_cfg_err        (cfgErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic flt, input logic clr);
    enable   = en;
    fault    = flt;
    faultClr = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitTick(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cycles++;
      if (periodTick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Each queued entry is the expected output set at the next carrier tick, 200 cycles apart for hp=100.
  task automatic drainScoreboard(input string tag);
    int       cycles;
    bit       ok;
    tickExp_t e;
    while (sbQ.size() > 0) begin
      waitTick(cycles, ok);
      e = sbQ.pop_front();
      if (!ok) begin
        checkOutput({tag, "_tick_timeout"}, 32'd0, 32'd1);
        sbQ.delete();
      end else begin
        checkOutput({tag, "_spacing"}, 32'(cycles), 32'd200);
        checkOutput({tag, "_duty"}, {11'd0, duty}, {11'd0, e.duty});
        checkOutput({tag, "_state"}, {30'd0, state}, {30'd0, e.state});
        checkOutput({tag, "_prot"}, {31'd0, protection}, {31'd0, e.prot});
      end
    end
  endtask

  task automatic pushExp(input logic [20:0] d, input logic [1:0] s, input logic p);
    tickExp_t e;
    e.duty  = d;
    e.state = s;
    e.prot  = p;
    sbQ.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_duty"}, {11'd0, duty}, 32'd0);
    checkOutput({tag, "_hp"}, {11'd0, halfPeriod}, 32'd1000);
    checkOutput({tag, "_dt"}, {11'd0, deadtime}, 32'd10);
    checkOutput({tag, "_prot"}, {31'd0, protection}, 32'd1);
    checkOutput({tag, "_state"}, {30'd0, state}, 32'd0);
    checkOutput({tag, "_tick"}, {31'd0, periodTick}, 32'd0);
    checkOutput({tag, "_cfgerr"}, {31'd0, cfgErr}, 32'd0);
  endtask

  initial begin
    cfgTable[0] = '{hp: 21'd3,   dt: 21'd0,   expErr: 1'b1, expState: 2'd0};
    cfgTable[1] = '{hp: 21'd2,   dt: 21'd0,   expErr: 1'b1, expState: 2'd0};
    cfgTable[2] = '{hp: 21'd100, dt: 21'd99,  expErr: 1'b1, expState: 2'd0};
    cfgTable[3] = '{hp: 21'd100, dt: 21'd120, expErr: 1'b1, expState: 2'd0};
    cfgTable[4] = '{hp: 21'd4,   dt: 21'd2,   expErr: 1'b0, expState: 2'd1};
    cfgTable[5] = '{hp: 21'd4,   dt: 21'd3,   expErr: 1'b1, expState: 2'd0};
    cfgTable[6] = '{hp: 21'd100, dt: 21'd98,  expErr: 1'b0, expState: 2'd1};

    rst_n = 1'b0;
    enable = 1'b0; fault = 1'b0; faultClr = 1'b0;
    tgtDuty = 21'd0; tgtHp = 21'd0; tgtDt = 21'd0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_hold_state", {30'd0, state}, 32'd0);

    $display("[TB] configuration check table");
    for (int i = 0; i < 7; i++) begin
      tgtHp = cfgTable[i].hp;
      tgtDt = cfgTable[i].dt;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("cfg%0d_state", i), {30'd0, state}, {30'd0, cfgTable[i].expState});
      checkOutput($sformatf("cfg%0d_err", i), {31'd0, cfgErr}, {31'd0, cfgTable[i].expErr});
      checkOutput($sformatf("cfg%0d_prot", i), {31'd0, protection}, {31'd0, cfgTable[i].expErr});
      if (!cfgTable[i].expErr) begin
        checkOutput($sformatf("cfg%0d_hp", i), {11'd0, halfPeriod}, {11'd0, cfgTable[i].hp});
        checkOutput($sformatf("cfg%0d_dt", i), {11'd0, deadtime}, {11'd0, cfgTable[i].dt});
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("cfg%0d_clr_state", i), {30'd0, state}, 32'd0);
      checkOutput($sformatf("cfg%0d_clr_err", i), {31'd0, cfgErr}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] soft-start to 40");
    tgtHp = 21'd100; tgtDt = 21'd5; tgtDuty = 21'd40;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_state", {30'd0, state}, 32'd1);
    checkOutput("start_prot", {31'd0, protection}, 32'd0);
    checkOutput("start_duty", {11'd0, duty}, 32'd0);
    pushExp(21'd10, 2'd1, 1'b0);
    pushExp(21'd20, 2'd1, 1'b0);
    pushExp(21'd30, 2'd1, 1'b0);
    pushExp(21'd40, 2'd2, 1'b0);
    drainScoreboard("soft");

    $display("[TB] clamp at ceiling");
    tgtDuty = 21'd150;
    pushExp(21'd50, 2'd2, 1'b0);
    pushExp(21'd60, 2'd2, 1'b0);
    pushExp(21'd70, 2'd2, 1'b0);
    pushExp(21'd80, 2'd2, 1'b0);
    pushExp(21'd90, 2'd2, 1'b0);
    pushExp(21'd94, 2'd2, 1'b0);
    pushExp(21'd94, 2'd2, 1'b0);
    drainScoreboard("clamp");

    $display("[TB] slew down then disable");
    tgtDuty = 21'd40;
    pushExp(21'd84, 2'd2, 1'b0);
    pushExp(21'd74, 2'd2, 1'b0);
    pushExp(21'd64, 2'd2, 1'b0);
    pushExp(21'd54, 2'd2, 1'b0);
    pushExp(21'd44, 2'd2, 1'b0);
    pushExp(21'd40, 2'd2, 1'b0);
    drainScoreboard("slew");
    enable = 1'b0;
    pushExp(21'd30, 2'd1, 1'b0);
    pushExp(21'd20, 2'd1, 1'b0);
    pushExp(21'd10, 2'd1, 1'b0);
    pushExp(21'd0,  2'd1, 1'b0);
    pushExp(21'd0,  2'd0, 1'b1);
    drainScoreboard("stop");

    $display("[TB] fault mid-ramp");
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushExp(21'd10, 2'd1, 1'b0);
    pushExp(21'd20, 2'd1, 1'b0);
    drainScoreboard("framp");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("fault_prot", {31'd0, protection}, 32'd1);
    checkOutput("fault_duty", {11'd0, duty}, 32'd0);
    checkOutput("fault_state", {30'd0, state}, 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("fault_clr_ignored", {30'd0, state}, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fault_held", {30'd0, state}, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("fault_cleared", {30'd0, state}, 32'd0);
    checkOutput("fault_cleared_prot", {31'd0, protection}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] async reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushExp(21'd10, 2'd1, 1'b0);
    pushExp(21'd20, 2'd1, 1'b0);
    pushExp(21'd30, 2'd1, 1'b0);
    pushExp(21'd40, 2'd2, 1'b0);
    drainScoreboard("rrun");
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_state", {30'd0, state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
